// File: rtl/wf_arb_pkg.sv
// Shared constants, FSM encoding and pointer helper for the wavefront issue arbiter.
package wf_arb_pkg;

  localparam int NUM_WF = 40;
  localparam int WFID_W = 6;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } arb_state_e;

  // Next slot after id, wrapping 39 -> 0.
  function automatic logic [WFID_W-1:0] wrap_inc(input logic [WFID_W-1:0] id);
    return (id >= WFID_W'(NUM_WF - 1)) ? '0 : id + 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick40.sv
// Combinational rotate-priority picker: first set bit of eligible_i at or after ptr_i, wrapping.
module rr_pick40
  import wf_arb_pkg::*;
(
  input  logic [NUM_WF-1:0] eligible_i,
  input  logic [WFID_W-1:0] ptr_i,
  output logic              found_o,
  output logic [WFID_W-1:0] wfid_o
);

  localparam logic [WFID_W:0] NWF = (WFID_W + 1)'(NUM_WF);

  always_comb begin
    logic [WFID_W:0] idx;
    logic            hit;
    hit    = 1'b0;
    wfid_o = '0;
    idx    = '0;
    for (int k = 0; k < NUM_WF; k++) begin
      idx = {1'b0, ptr_i} + (WFID_W + 1)'(k);
      if (idx >= NWF) idx = idx - NWF;
      if (!hit && eligible_i[idx[WFID_W-1:0]]) begin
        hit    = 1'b1;
        wfid_o = idx[WFID_W-1:0];
      end
    end
    found_o = hit;
  end

endmodule

// File: rtl/wf_issue_arbiter.sv
// Round-robin issue arbiter over 40 wavefront slots with busy tracking and a registered valid/ready grant.
module wf_issue_arbiter
  import wf_arb_pkg::*;
#(
  parameter int NUM_WF = wf_arb_pkg::NUM_WF,
  parameter int WFID_W = wf_arb_pkg::WFID_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_WF-1:0] req,
  input  logic              done_valid,
  input  logic [WFID_W-1:0] done_wfid,
  output logic              grant_valid,
  input  logic              grant_ready,
  output logic [WFID_W-1:0] grant_wfid,
  output logic [NUM_WF-1:0] grant_onehot,
  output logic [NUM_WF-1:0] busy,
  output logic              done_err
);

  arb_state_e        state_q, state_d;
  logic [WFID_W-1:0] grant_wfid_q, grant_wfid_d;
  logic [WFID_W-1:0] last_q, last_d;
  logic [NUM_WF-1:0] busy_q, busy_d;
  logic              done_err_q, done_err_d;

  logic              hs;
  logic              done_ok;
  logic              pick_found;
  logic [WFID_W-1:0] pick_wfid;
  logic [WFID_W-1:0] ptr;
  logic [NUM_WF-1:0] held_oh;
  logic [NUM_WF-1:0] done_oh;
  logic [NUM_WF-1:0] eligible;

  assign grant_valid  = (state_q == ST_OFFER);
  assign held_oh      = grant_valid ? (NUM_WF'(1) << grant_wfid_q) : '0;
  assign hs           = grant_valid & grant_ready;
  assign eligible     = req & ~busy_q & ~held_oh;
  // On a handshake the search restarts right after the ID being accepted now.
  assign ptr          = hs ? wrap_inc(grant_wfid_q) : wrap_inc(last_q);
  assign done_oh      = (done_wfid < WFID_W'(NUM_WF)) ? (NUM_WF'(1) << done_wfid) : '0;
  assign done_ok      = done_valid & (|(busy_q & done_oh));

  assign grant_wfid   = grant_wfid_q;
  assign grant_onehot = held_oh;
  assign busy         = busy_q;
  assign done_err     = done_err_q;

  rr_pick40 u_pick (
    .eligible_i (eligible),
    .ptr_i      (ptr),
    .found_o    (pick_found),
    .wfid_o     (pick_wfid)
  );

  always_comb begin
    state_d      = state_q;
    grant_wfid_d = grant_wfid_q;
    last_d       = last_q;
    busy_d       = busy_q & ~(done_ok ? done_oh : '0);
    done_err_d   = done_valid & ~done_ok;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d      = ST_OFFER;
          grant_wfid_d = pick_wfid;
        end
      end
      ST_OFFER: begin
        if (hs) begin
          // Setting after the clear lets an issue win over a same-cycle completion.
          busy_d = busy_d | held_oh;
          last_d = grant_wfid_q;
          if (pick_found) grant_wfid_d = pick_wfid;
          else            state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      grant_wfid_q <= '0;
      last_q       <= WFID_W'(NUM_WF - 1);
      busy_q       <= '0;
      done_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_wfid_q <= grant_wfid_d;
      last_q       <= last_d;
      busy_q       <= busy_d;
      done_err_q   <= done_err_d;
    end
  end

endmodule

// File: tb/tb_wf_issue_arbiter.sv
// Bench for wf_issue_arbiter: directed scenarios plus random traffic against a slot-level reference model.
module tb_wf_issue_arbiter;

  localparam int N = 40;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic          done_valid;
  logic [5:0]    done_wfid;
  logic          grant_valid;
  logic          grant_ready;
  logic [5:0]    grant_wfid;
  logic [N-1:0]  grant_onehot;
  logic [N-1:0]  busy;
  logic          done_err;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: slot flags and integers, not RTL state.
  bit m_busy[N];
  bit m_valid;
  int m_id;
  int m_last;
  bit m_derr;

  wf_issue_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .done_valid   (done_valid),
    .done_wfid    (done_wfid),
    .grant_valid  (grant_valid),
    .grant_ready  (grant_ready),
    .grant_wfid   (grant_wfid),
    .grant_onehot (grant_onehot),
    .busy         (busy),
    .done_err     (done_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_find(input bit e[N], input int start);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (start + k) % N;
      if (e[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] busy_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_step();
    bit e[N];
    bit nb[N];
    bit hs;
    int p;
    int dw;
    if (!rst) begin
      for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
      m_valid = 1'b0;
      m_id    = 0;
      m_last  = N - 1;
      m_derr  = 1'b0;
      return;
    end
    hs = m_valid && grant_ready;
    for (int i = 0; i < N; i++) begin
      e[i]  = req[i] && !m_busy[i] && !(m_valid && i == m_id);
      nb[i] = m_busy[i];
    end
    dw     = int'(done_wfid);
    m_derr = done_valid && (dw >= N || !m_busy[dw]);
    if (done_valid && !m_derr) nb[dw] = 1'b0;
    if (!m_valid) begin
      p = rr_find(e, (m_last + 1) % N);
      if (p >= 0) begin
        m_valid = 1'b1;
        m_id    = p;
      end
    end else if (hs) begin
      nb[m_id] = 1'b1;
      m_last   = m_id;
      p = rr_find(e, (m_id + 1) % N);
      if (p >= 0) m_id = p;
      else        m_valid = 1'b0;
    end
    for (int i = 0; i < N; i++) m_busy[i] = nb[i];
  endtask

  task automatic check_model();
    logic [N-1:0] oh;
    oh = m_valid ? (N'(1) << m_id) : '0;
    chk("grant_valid", 64'(grant_valid), 64'(m_valid));
    if (m_valid) chk("grant_wfid", 64'(grant_wfid), 64'(m_id));
    chk("grant_onehot", 64'(grant_onehot), 64'(oh));
    chk("busy", 64'(busy), 64'(busy_vec()));
    chk("done_err", 64'(done_err), 64'(m_derr));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    req         = '0;
    done_valid  = 1'b0;
    done_wfid   = '0;
    grant_ready = 1'b0;
    cycle();
    rst = 1'b1;
  endtask

  initial begin
    logic [N-1:0] all_ones;
    all_ones = '1;

    // Reset state.
    rst = 1'b0; req = '0; done_valid = 1'b0; done_wfid = '0; grant_ready = 1'b0;
    do_reset();
    chk("rst_gv", 64'(grant_valid), 64'd0);
    chk("rst_wfid", 64'(grant_wfid), 64'd0);
    chk("rst_onehot", 64'(grant_onehot), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_derr", 64'(done_err), 64'd0);

    // Single request: latency 1, busy after handshake.
    req = 40'h1;
    cycle();
    chk("first_gv", 64'(grant_valid), 64'd1);
    chk("first_wfid", 64'(grant_wfid), 64'd0);
    grant_ready = 1'b1;
    cycle();
    chk("first_busy", 64'(busy), 64'h1);

    // All requesting with ready high: 0..39 back to back, then idle.
    do_reset();
    req = all_ones;
    grant_ready = 1'b1;
    cycle();
    for (int i = 0; i < N; i++) begin
      chk("rr_gv", 64'(grant_valid), 64'd1);
      chk("rr_seq", 64'(grant_wfid), 64'(i));
      cycle();
    end
    chk("rr_end_gv", 64'(grant_valid), 64'd0);
    chk("rr_end_busy", 64'(busy), 64'(all_ones));

    // Bits 5 and 38 from reset pointer, then wrap past 39.
    do_reset();
    req = (N'(1) << 5) | (N'(1) << 38);
    cycle();
    chk("wrap_a", 64'(grant_wfid), 64'd5);
    grant_ready = 1'b1;
    cycle();
    chk("wrap_b", 64'(grant_wfid), 64'd38);
    cycle();
    chk("wrap_idle", 64'(grant_valid), 64'd0);
    req = '0; grant_ready = 1'b0;
    done_valid = 1'b1; done_wfid = 6'd5;  cycle();
    done_wfid = 6'd38; cycle();
    done_valid = 1'b0; cycle();
    req = (N'(1) << 5) | (N'(1) << 38);
    cycle();
    chk("wrap_c", 64'(grant_wfid), 64'd5);

    // Held offer survives req drop while stalled.
    do_reset();
    req = N'(1) << 7;
    cycle();
    for (int c = 0; c < 4; c++) begin
      if (c == 2) req = '0;
      cycle();
      chk("hold_wfid", 64'(grant_wfid), 64'd7);
      chk("hold_busy", 64'(busy), 64'd0);
    end
    grant_ready = 1'b1;
    cycle();
    chk("hold_hs_busy", 64'(busy), 64'(N'(1) << 7));

    // Completion, double completion and out-of-range completion.
    do_reset();
    req = N'(1) << 12; grant_ready = 1'b1;
    cycle(); cycle();
    req = '0;
    chk("c12_busy", 64'(busy[12]), 64'd1);
    done_valid = 1'b1; done_wfid = 6'd12; cycle();
    chk("c12_clr", 64'(busy[12]), 64'd0);
    chk("c12_ok", 64'(done_err), 64'd0);
    cycle();
    chk("c12_again", 64'(done_err), 64'd1);
    done_valid = 1'b0; cycle();
    chk("c12_pulse", 64'(done_err), 64'd0);
    done_valid = 1'b1; done_wfid = 6'd45; cycle();
    chk("c45_err", 64'(done_err), 64'd1);
    done_valid = 1'b0;

    // Issue and completion on the same ID, then reset during an offer.
    do_reset();
    req = N'(1) << 3;
    cycle();
    grant_ready = 1'b1; done_valid = 1'b1; done_wfid = 6'd3;
    cycle();
    chk("same_busy", 64'(busy[3]), 64'd1);
    done_valid = 1'b0; grant_ready = 1'b0;
    req = N'(1) << 9;
    cycle();
    chk("pre_rst_gv", 64'(grant_valid), 64'd1);
    rst = 1'b0;
    cycle();
    chk("mid_rst_gv", 64'(grant_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    rst = 1'b1;

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      int nb;
      int pick;
      rst = ($urandom_range(0, 299) != 0);
      for (int i = 0; i < N; i++) req[i] = ($urandom_range(0, 3) == 0);
      grant_ready = ($urandom_range(0, 3) != 0);
      done_valid  = ($urandom_range(0, 2) == 0);
      nb = 0;
      for (int i = 0; i < N; i++) if (m_busy[i]) nb++;
      if (nb > 0 && $urandom_range(0, 4) != 0) begin
        pick = $urandom_range(0, nb - 1);
        for (int i = 0; i < N; i++) begin
          if (m_busy[i]) begin
            if (pick == 0) done_wfid = 6'(i);
            pick--;
          end
        end
      end else begin
        done_wfid = 6'($urandom_range(0, 63));
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wf_issue_arbiter.md
WF_ISSUE_ARBITER -- requirements
Module: wf_issue_arbiter

Interface
REQ-001 SHALL have parameter NUM_WF, default 40, number of wavefront slots (fixed at 40; other values unsupported).
REQ-002 SHALL have parameter WFID_W, default 6, width of wavefront ID and mux select.
REQ-003 SHALL have ports: clk  in  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have ports: rst  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports: req  in  40  per-wavefront issue request, level-sensitive.
REQ-006 SHALL have ports: done_valid  in  1  completion strobe from the execution unit.
REQ-007 SHALL have ports: done_wfid  in  6  wavefront ID completing.
REQ-008 SHALL have ports: grant_valid  out  1  grant offered downstream.
REQ-009 SHALL have ports: grant_ready  in  1  downstream accepts grant.
REQ-010 SHALL have ports: grant_wfid  out  6  granted ID; drives the select of the 40:1 operand mux.
REQ-011 SHALL have ports: grant_onehot  out  40  one-hot of grant_wfid, zero when grant_valid=0.
REQ-012 SHALL have ports: busy  out  40  wavefront issued and not yet completed.
REQ-013 SHALL have ports: done_err  out  1  one-cycle pulse on illegal completion.

Function
REQ-014 SHALL compute eligible = req & ~busy, excluding any ID currently held in grant_wfid while grant_valid=1.
REQ-015 SHALL select round-robin: search starts at ptr = (last_issued+1) mod 40, wraps 39->0, picks first eligible ID.
REQ-016 SHALL implement FSM IDLE/OFFER: IDLE->OFFER when eligible!=0; OFFER->OFFER on handshake with a new eligible pick; OFFER->IDLE on handshake with none eligible; OFFER holds otherwise.
REQ-017 SHALL register the grant: eligible at cycle N in IDLE -> grant_valid=1 at N+1 (latency 1).
REQ-018 SHALL hold grant_wfid and grant_onehot stable while grant_valid=1 and grant_ready=0, even if req for that ID deasserts.
REQ-019 SHALL treat grant_valid&grant_ready as handshake: set busy[grant_wfid], last_issued<=grant_wfid, and, if any other ID is eligible, present the next grant the following cycle (1 grant/cycle sustained).
REQ-020 SHALL clear busy[done_wfid] on the cycle after done_valid=1; the cleared ID is eligible from that cycle.
REQ-021 SHALL, when handshake and done_valid target the same ID in one cycle, leave busy set (set wins).
REQ-022 SHALL pulse done_err and ignore the completion when done_valid=1 and busy[done_wfid]=0, or done_wfid>=40.
REQ-023 SHALL never offer an ID >=40 and never offer a busy ID.
REQ-024 SHALL not change last_issued without a handshake.

Reset
REQ-025 SHALL, with rst=0 at a clock edge, set state=IDLE, grant_valid=0, grant_wfid=0, grant_onehot=0, busy=0, done_err=0, last_issued=39 (ptr=0).
REQ-026 SHALL abandon any pending offer on reset without setting busy; outputs take reset values the cycle after the edge.

Structure
REQ-027 SHALL place NUM_WF, WFID_W and the FSM state encoding in shared package wf_arb_pkg.
REQ-028 SHALL use one sub-module, rr_pick40: combinational 40-bit rotate-priority picker (eligible, ptr -> found, wfid).

Verification
REQ-029 Reset then req=40'h1 at cycle 1 -> grant_valid=1, grant_wfid=0 at cycle 2; grant_ready=1 -> busy=40'h1 at cycle 3.
REQ-030 req=all ones, grant_ready=1 constant -> grant_wfid sequence 0,1,...,39 on consecutive cycles, then grant_valid=0 (all busy).
REQ-031 last_issued=39, req bits 5 and 38 set -> grant_wfid=5; next grant 38; wrap order verified.
REQ-032 Offer wfid=7 with grant_ready=0 for 4 cycles, req[7] dropped at cycle 2 -> grant_wfid stays 7, busy unchanged until handshake.
REQ-033 busy[12]=1, done_valid=1 done_wfid=12 -> busy[12]=0 next cycle; done_wfid=12 again -> done_err=1 one cycle; done_wfid=45 -> done_err=1.
REQ-034 Handshake on wfid=3 with simultaneous done_wfid=3 -> busy[3]=1; rst=0 during an offer -> grant_valid=0, busy=0 next cycle.
